// File: rtl/traffic_pkg.sv
// Shared definitions for the Breadboard intersection controller: phase codes,
// approach and lane indices, and helpers that map approaches onto lane bits.
package traffic_pkg;

    typedef logic [2:0] mode_t;
    typedef logic [1:0] approach_t;

    localparam mode_t ST_GREEN  = 3'd0;
    localparam mode_t ST_YELLOW = 3'd1;
    localparam mode_t ST_ALLRED = 3'd2;
    localparam mode_t ST_PED    = 3'd3;
    localparam mode_t ST_EMG    = 3'd4;

    localparam approach_t APP_N = 2'd0;
    localparam approach_t APP_E = 2'd1;
    localparam approach_t APP_S = 2'd2;
    localparam approach_t APP_W = 2'd3;

    localparam int unsigned LANE_N2 = 32'd0;
    localparam int unsigned LANE_N1 = 32'd1;
    localparam int unsigned LANE_E2 = 32'd2;
    localparam int unsigned LANE_E1 = 32'd3;
    localparam int unsigned LANE_S2 = 32'd4;
    localparam int unsigned LANE_S1 = 32'd5;
    localparam int unsigned LANE_W2 = 32'd6;
    localparam int unsigned LANE_W1 = 32'd7;

    function automatic logic [7:0] approach_mask(input approach_t app);
        return 8'b0000_0011 << {app, 1'b0};
    endfunction

    // Sum of the two 8-bit queue counts owned by an approach, widened so it cannot wrap.
    function automatic logic [8:0] approach_score(input logic [63:0] lanes, input approach_t app);
        logic [5:0] base;
        base = {app, 4'b0000};
        return {1'b0, lanes[base +: 8]} + {1'b0, lanes[base + 6'd8 +: 8]};
    endfunction

    function automatic approach_t emergency_approach(input logic [7:0] lane_bits);
        approach_t app;
        if (|lane_bits[7:6]) begin
            app = APP_W;
        end else if (|lane_bits[5:4]) begin
            app = APP_S;
        end else if (|lane_bits[3:2]) begin
            app = APP_E;
        end else begin
            app = APP_N;
        end
        return app;
    endfunction

endpackage

// File: rtl/approach_select.sv
// Combinational choice of the next approach to serve: heaviest demand wins,
// ties broken in rotational order after the current approach.
module approach_select
    import traffic_pkg::*;
(
    input  logic [63:0] lanes_i,
    input  logic [1:0]  cur_approach_i,
    output logic [1:0]  next_approach_o
);

    logic [8:0] score_s [4];
    logic [1:0] best_app_s;
    logic [1:0] cand_s;
    logic [8:0] best_score_s;
    logic       others_zero_s;

    // Demand per approach.
    always_comb begin
        for (int a = 0; a < 4; a++) begin
            score_s[a] = approach_score(lanes_i, 2'(a));
        end
    end

    // Scan the other three approaches starting at cur+1; strict compare keeps the earliest on ties.
    always_comb begin
        best_app_s    = cur_approach_i + 2'd1;
        best_score_s  = score_s[best_app_s];
        others_zero_s = (best_score_s == 9'd0);
        cand_s        = 2'd0;
        for (int k = 2; k < 4; k++) begin
            cand_s = cur_approach_i + 2'(k);
            if (score_s[cand_s] != 9'd0) begin
                others_zero_s = 1'b0;
            end else begin
                others_zero_s = others_zero_s;
            end
            if (score_s[cand_s] > best_score_s) begin
                best_score_s = score_s[cand_s];
                best_app_s   = cand_s;
            end else begin
                best_score_s = best_score_s;
            end
        end
        // The current approach keeps the green only when nobody else is waiting.
        if (others_zero_s && (score_s[cur_approach_i] != 9'd0)) begin
            next_approach_o = cur_approach_i;
        end else begin
            next_approach_o = best_app_s;
        end
    end

endmodule

// File: rtl/phase_scheduler.sv
// Intersection phase controller: owns the phase FSM, the countdown timer,
// the pedestrian latch and the registered lamp masks.
module phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_DAY   = 32'd20,
    parameter int unsigned GREEN_NIGHT = 32'd8,
    parameter int unsigned YELLOW_TIME = 32'd3,
    parameter int unsigned ALLRED_TIME = 32'd1,
    parameter int unsigned PED_TIME    = 32'd10,
    parameter int unsigned EMG_MIN     = 32'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] lanes,
    input  logic        dayNightSignal,
    input  logic        pedSignal,
    input  logic        emgSignal,
    input  logic [7:0]  emgLane,
    output logic [7:0]  trafficLightOutput,
    output logic [7:0]  amberOutput,
    output logic [7:0]  walkingLightOutput,
    output logic [2:0]  trafficMode,
    output logic [7:0]  currentCount,
    output logic [1:0]  activeApproach
);

    localparam logic [7:0] LD_GREEN_DAY   = 8'(GREEN_DAY - 32'd1);
    localparam logic [7:0] LD_GREEN_NIGHT = 8'(GREEN_NIGHT - 32'd1);
    localparam logic [7:0] LD_YELLOW      = 8'(YELLOW_TIME - 32'd1);
    localparam logic [7:0] LD_ALLRED      = 8'(ALLRED_TIME - 32'd1);
    localparam logic [7:0] LD_PED         = 8'(PED_TIME - 32'd1);
    localparam logic [7:0] LD_EMG         = 8'(EMG_MIN - 32'd1);

    mode_t      mode_q, mode_d;
    logic [7:0] count_q, count_d;
    approach_t  app_q, app_d;
    logic       ped_q, ped_d;
    logic [7:0] green_q, green_d;
    logic [7:0] amber_q, amber_d;
    logic [7:0] walk_q, walk_d;

    approach_t  sel_app_s;
    approach_t  emg_app_s;
    logic       emg_valid_s;
    logic       expired_s;

    approach_select u_select (
        .lanes_i         (lanes),
        .cur_approach_i  (app_q),
        .next_approach_o (sel_app_s)
    );

    assign emg_valid_s = emgSignal && (emgLane != 8'h00);
    assign emg_app_s   = emergency_approach(emgLane);
    assign expired_s   = (count_q == 8'd0);

    // Next phase, countdown and served approach.
    always_comb begin
        mode_d  = mode_q;
        count_d = expired_s ? 8'd0 : (count_q - 8'd1);
        app_d   = app_q;
        ped_d   = ped_q | pedSignal;
        case (mode_q)
            ST_GREEN: begin
                if (emg_valid_s && (emg_app_s != app_q)) begin
                    mode_d  = ST_YELLOW;
                    count_d = LD_YELLOW;
                end else if (emg_valid_s) begin
                    mode_d  = ST_EMG;
                    count_d = LD_EMG;
                end else if (expired_s) begin
                    mode_d  = ST_YELLOW;
                    count_d = LD_YELLOW;
                end else begin
                    mode_d  = ST_GREEN;
                end
            end
            ST_YELLOW: begin
                if (expired_s) begin
                    mode_d  = ST_ALLRED;
                    count_d = LD_ALLRED;
                end else begin
                    mode_d  = ST_YELLOW;
                end
            end
            ST_ALLRED: begin
                if (!expired_s) begin
                    mode_d  = ST_ALLRED;
                end else if (emg_valid_s) begin
                    mode_d  = ST_EMG;
                    count_d = LD_EMG;
                    app_d   = emg_app_s;
                end else if (ped_q) begin
                    // A request arriving on this very edge is served by this walk phase.
                    mode_d  = ST_PED;
                    count_d = LD_PED;
                    ped_d   = 1'b0;
                end else begin
                    mode_d  = ST_GREEN;
                    count_d = dayNightSignal ? LD_GREEN_DAY : LD_GREEN_NIGHT;
                    app_d   = sel_app_s;
                end
            end
            ST_PED: begin
                if (emg_valid_s || expired_s) begin
                    mode_d  = ST_ALLRED;
                    count_d = LD_ALLRED;
                end else begin
                    mode_d  = ST_PED;
                end
            end
            ST_EMG: begin
                if (!emgSignal && expired_s) begin
                    mode_d  = ST_YELLOW;
                    count_d = LD_YELLOW;
                end else begin
                    mode_d  = ST_EMG;
                end
            end
            default: begin
                mode_d  = ST_ALLRED;
                count_d = LD_ALLRED;
            end
        endcase
    end

    // Lamp masks derived from the next state so they line up with the state register.
    always_comb begin
        green_d = 8'h00;
        amber_d = 8'h00;
        walk_d  = 8'h00;
        case (mode_d)
            ST_GREEN, ST_EMG: green_d = approach_mask(app_d);
            ST_YELLOW:        amber_d = approach_mask(app_d);
            ST_PED:           walk_d  = 8'hFF;
            default: begin
                green_d = 8'h00;
                amber_d = 8'h00;
                walk_d  = 8'h00;
            end
        endcase
    end

    // State, timer, latch and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q  <= ST_ALLRED;
            count_q <= LD_ALLRED;
            app_q   <= APP_W;
            ped_q   <= 1'b0;
            green_q <= 8'h00;
            amber_q <= 8'h00;
            walk_q  <= 8'h00;
        end else begin
            mode_q  <= mode_d;
            count_q <= count_d;
            app_q   <= app_d;
            ped_q   <= ped_d;
            green_q <= green_d;
            amber_q <= amber_d;
            walk_q  <= walk_d;
        end
    end

    assign trafficLightOutput = green_q;
    assign amberOutput        = amber_q;
    assign walkingLightOutput = walk_q;
    assign trafficMode        = mode_q;
    assign currentCount       = count_q;
    assign activeApproach     = app_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// Self-checking bench for phase_scheduler: directed scenarios plus a random run
// compared every cycle against a remaining-cycles behavioural model.
module tb_phase_scheduler;

    localparam int GD = 20;
    localparam int GN = 8;
    localparam int YT = 3;
    localparam int AR = 1;
    localparam int PT = 10;
    localparam int EM = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] lanes;
    logic        dn;
    logic        ped;
    logic        emg;
    logic [7:0]  emg_lane;
    logic [7:0]  tlo;
    logic [7:0]  amb;
    logic [7:0]  walk;
    logic [2:0]  mode;
    logic [7:0]  cnt;
    logic [1:0]  app;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase code, cycles left in the phase (including the present one), approach, pending walk.
    int m_mode = 2;
    int m_left = AR;
    int m_app  = 3;
    bit m_ped  = 1'b0;

    always #5 clk = ~clk;

    phase_scheduler #(
        .GREEN_DAY(GD), .GREEN_NIGHT(GN), .YELLOW_TIME(YT),
        .ALLRED_TIME(AR), .PED_TIME(PT), .EMG_MIN(EM)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .lanes              (lanes),
        .dayNightSignal     (dn),
        .pedSignal          (ped),
        .emgSignal          (emg),
        .emgLane            (emg_lane),
        .trafficLightOutput (tlo),
        .amberOutput        (amb),
        .walkingLightOutput (walk),
        .trafficMode        (mode),
        .currentCount       (cnt),
        .activeApproach     (app)
    );

    function automatic int m_emg_app(input logic [7:0] el);
        for (int i = 7; i >= 0; i--) begin
            if (el[i]) return i / 2;
        end
        return 0;
    endfunction

    function automatic int m_select(input logic [63:0] ln, input int cur);
        int s[4];
        int best;
        int bs;
        bit others_zero;
        for (int a = 0; a < 4; a++) begin
            s[a] = int'(ln[16*a +: 8]) + int'(ln[16*a+8 +: 8]);
        end
        others_zero = 1'b1;
        for (int k = 1; k < 4; k++) begin
            if (s[(cur + k) % 4] != 0) others_zero = 1'b0;
        end
        if (others_zero) return (s[cur] != 0) ? cur : (cur + 1) % 4;
        best = -1;
        bs   = -1;
        for (int k = 1; k < 4; k++) begin
            if (s[(cur + k) % 4] > bs) begin
                bs   = s[(cur + k) % 4];
                best = (cur + k) % 4;
            end
        end
        return best;
    endfunction

    task automatic model_step();
        int  nm;
        int  nl;
        int  na;
        bit  np;
        bit  ev;
        bit  done;
        int  ea;
        if (!rst) begin
            m_mode = 2; m_left = AR; m_app = 3; m_ped = 1'b0;
            return;
        end
        ev   = emg && (emg_lane != 8'h00);
        ea   = m_emg_app(emg_lane);
        done = (m_left == 1);
        nm = m_mode;
        nl = (m_left > 1) ? m_left - 1 : 1;
        na = m_app;
        np = m_ped || ped;
        if (m_mode == 0) begin
            if (ev && ea != m_app) begin nm = 1; nl = YT; end
            else if (ev)           begin nm = 4; nl = EM; end
            else if (done)         begin nm = 1; nl = YT; end
        end else if (m_mode == 1) begin
            if (done) begin nm = 2; nl = AR; end
        end else if (m_mode == 2) begin
            if (done) begin
                if (ev)         begin nm = 4; nl = EM; na = ea; end
                else if (m_ped) begin nm = 3; nl = PT; np = 1'b0; end
                else            begin nm = 0; nl = dn ? GD : GN; na = m_select(lanes, m_app); end
            end
        end else if (m_mode == 3) begin
            if (ev || done) begin nm = 2; nl = AR; end
        end else if (m_mode == 4) begin
            if (!emg && done) begin nm = 1; nl = YT; end
        end
        m_mode = nm; m_left = nl; m_app = na; m_ped = np;
    endtask

    function automatic logic [36:0] m_vec();
        logic [7:0] base;
        logic [7:0] mask;
        logic [7:0] g;
        logic [7:0] a;
        logic [7:0] w;
        base = 8'h03;
        mask = base << (2 * m_app);
        g = (m_mode == 0 || m_mode == 4) ? mask : 8'h00;
        a = (m_mode == 1) ? mask : 8'h00;
        w = (m_mode == 3) ? 8'hFF : 8'h00;
        return {g, a, w, 3'(m_mode), 8'(m_left - 1), 2'(m_app)};
    endfunction

    function automatic logic [36:0] dut_vec();
        return {tlo, amb, walk, mode, cnt, app};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [36:0] exp_v;
        exp_v = {8'h00, 8'h00, 8'h00, 3'd2, 8'd0, 2'd3};
        lanes = {$urandom, $urandom}; dn = 1'b1; ped = 1'b1; emg = 1'b1; emg_lane = 8'h10;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_checks++;
            if (dut_vec() !== exp_v) begin
                n_errors++;
                $display("FAIL reset k=%0d got=%h expected=%h", k, dut_vec(), exp_v);
            end
        end
        rst = 1'b1; ped = 1'b0; emg = 1'b0;
    endtask

    task automatic test_first_selection();
        logic [31:0] e;
        lanes = 64'h0; lanes[47:40] = 8'h7F; lanes[15:8] = 8'h07;
        dn = 1'b1; ped = 1'b0; emg = 1'b0; emg_lane = 8'h00;
        do_reset();
        for (int k = 1; k <= 25; k++) begin
            cycle();
            if (k <= 20)      e = {8'd0, 8'h30, 8'h00, 8'h00};
            else if (k <= 23) e = {8'd1, 8'h00, 8'h30, 8'h00};
            else if (k == 24) e = {8'd2, 8'h00, 8'h00, 8'h00};
            else              e = {8'd0, 8'h03, 8'h00, 8'h00};
            n_checks++;
            if ({5'd0, mode, tlo, amb, walk} !== e) begin
                n_errors++;
                $display("FAIL first_sel_seq k=%0d got=%h expected=%h", k, {5'd0, mode, tlo, amb, walk}, e);
            end
            n_checks++;
            if (dut_vec() !== m_vec()) begin
                n_errors++;
                $display("FAIL first_sel_model k=%0d got=%h expected=%h", k, dut_vec(), m_vec());
            end
        end
    endtask

    task automatic test_night_rotation();
        logic [7:0]  base;
        logic [7:0]  mask;
        logic [31:0] e;
        int idx;
        base = 8'h03;
        lanes = 64'h0; dn = 1'b0; ped = 1'b0; emg = 1'b0; emg_lane = 8'h00;
        do_reset();
        for (int k = 1; k <= 49; k++) begin
            cycle();
            idx  = (k - 1) % 12;
            mask = base << (2 * (((k - 1) / 12) % 4));
            if (idx < 8)       e = {8'd0, mask, 8'h00, 8'h00};
            else if (idx < 11) e = {8'd1, 8'h00, mask, 8'h00};
            else               e = {8'd2, 8'h00, 8'h00, 8'h00};
            n_checks++;
            if ({5'd0, mode, tlo, amb, walk} !== e) begin
                n_errors++;
                $display("FAIL night_rotation k=%0d got=%h expected=%h", k, {5'd0, mode, tlo, amb, walk}, e);
            end
        end
    endtask

    task automatic test_ped();
        logic [31:0] e;
        lanes = 64'h0; dn = 1'b0; emg = 1'b0; emg_lane = 8'h00;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            ped = (k == 3);
            cycle();
            if (k <= 8)       e = {8'd0, 8'h03, 8'h00, 8'h00};
            else if (k <= 11) e = {8'd1, 8'h00, 8'h03, 8'h00};
            else if (k == 12) e = {8'd2, 8'h00, 8'h00, 8'h00};
            else if (k <= 22) e = {8'd3, 8'h00, 8'h00, 8'hFF};
            else if (k == 23) e = {8'd2, 8'h00, 8'h00, 8'h00};
            else              e = {8'd0, 8'h0C, 8'h00, 8'h00};
            n_checks++;
            if ({5'd0, mode, tlo, amb, walk} !== e) begin
                n_errors++;
                $display("FAIL ped k=%0d got=%h expected=%h", k, {5'd0, mode, tlo, amb, walk}, e);
            end
        end
        ped = 1'b0;
    endtask

    task automatic test_emg_other();
        logic [31:0] e;
        lanes = 64'h0; dn = 1'b0; ped = 1'b0; emg_lane = 8'h08;
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            emg = (k >= 3 && k <= 8);
            cycle();
            if (k <= 2)       e = {8'd0, 8'h03, 8'h00, 8'h00};
            else if (k <= 5)  e = {8'd1, 8'h00, 8'h03, 8'h00};
            else if (k == 6)  e = {8'd2, 8'h00, 8'h00, 8'h00};
            else if (k <= 21) e = {8'd4, 8'h0C, 8'h00, 8'h00};
            else if (k <= 24) e = {8'd1, 8'h00, 8'h0C, 8'h00};
            else if (k == 25) e = {8'd2, 8'h00, 8'h00, 8'h00};
            else              e = {8'd0, 8'h30, 8'h00, 8'h00};
            n_checks++;
            if ({5'd0, mode, tlo, amb, walk} !== e) begin
                n_errors++;
                $display("FAIL emg_other k=%0d got=%h expected=%h", k, {5'd0, mode, tlo, amb, walk}, e);
            end
        end
        emg = 1'b0;
    endtask

    task automatic test_emg_during_ped();
        logic [31:0] e;
        lanes = 64'h0; dn = 1'b0; emg_lane = 8'h80;
        do_reset();
        for (int k = 1; k <= 45; k++) begin
            ped = (k == 2);
            emg = (k >= 15 && k <= 40);
            cycle();
            if (k <= 8)       e = {8'd0, 8'h03, 8'h00, 8'h00};
            else if (k <= 11) e = {8'd1, 8'h00, 8'h03, 8'h00};
            else if (k == 12) e = {8'd2, 8'h00, 8'h00, 8'h00};
            else if (k <= 14) e = {8'd3, 8'h00, 8'h00, 8'hFF};
            else if (k == 15) e = {8'd2, 8'h00, 8'h00, 8'h00};
            else if (k <= 40) e = {8'd4, 8'hC0, 8'h00, 8'h00};
            else if (k <= 43) e = {8'd1, 8'h00, 8'hC0, 8'h00};
            else if (k == 44) e = {8'd2, 8'h00, 8'h00, 8'h00};
            else              e = {8'd0, 8'h03, 8'h00, 8'h00};
            n_checks++;
            if ({5'd0, mode, tlo, amb, walk} !== e) begin
                n_errors++;
                $display("FAIL emg_ped k=%0d got=%h expected=%h", k, {5'd0, mode, tlo, amb, walk}, e);
            end
        end
        ped = 1'b0; emg = 1'b0;
    endtask

    task automatic test_emg_same();
        logic [31:0] e;
        lanes = 64'h0; lanes[47:40] = 8'h7F; dn = 1'b1; ped = 1'b0; emg_lane = 8'h20;
        do_reset();
        for (int k = 1; k <= 23; k++) begin
            emg = (k == 4);
            cycle();
            if (k <= 3)       e = {8'd0, 8'h30, 8'h00, 8'h00};
            else if (k <= 18) e = {8'd4, 8'h30, 8'h00, 8'h00};
            else if (k <= 21) e = {8'd1, 8'h00, 8'h30, 8'h00};
            else if (k == 22) e = {8'd2, 8'h00, 8'h00, 8'h00};
            else              e = {8'd0, 8'h30, 8'h00, 8'h00};
            n_checks++;
            if ({5'd0, mode, tlo, amb, walk} !== e) begin
                n_errors++;
                $display("FAIL emg_same k=%0d got=%h expected=%h", k, {5'd0, mode, tlo, amb, walk}, e);
            end
        end
        emg = 1'b0;
    endtask

    task automatic test_invalid_emg();
        logic [31:0] e;
        lanes = 64'h0; dn = 1'b0; ped = 1'b0; emg = 1'b1; emg_lane = 8'h00;
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            cycle();
            if (k <= 8)       e = {8'd0, 8'h03, 8'h00, 8'h00};
            else if (k <= 11) e = {8'd1, 8'h00, 8'h03, 8'h00};
            else if (k == 12) e = {8'd2, 8'h00, 8'h00, 8'h00};
            else              e = {8'd0, 8'h0C, 8'h00, 8'h00};
            n_checks++;
            if ({5'd0, mode, tlo, amb, walk} !== e) begin
                n_errors++;
                $display("FAIL invalid_emg k=%0d got=%h expected=%h", k, {5'd0, mode, tlo, amb, walk}, e);
            end
        end
        emg = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [36:0] e;
        lanes = 64'h0; dn = 1'b0; ped = 1'b0; emg_lane = 8'h01;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            emg = (k <= 5);
            rst = (k != 5);
            cycle();
            if (k <= 4)      e = {8'h03, 8'h00, 8'h00, 3'd4, 8'(EM - k), 2'd0};
            else if (k == 5) e = {8'h00, 8'h00, 8'h00, 3'd2, 8'd0, 2'd3};
            else             e = {8'h03, 8'h00, 8'h00, 3'd0, 8'(GN - 1), 2'd0};
            n_checks++;
            if (dut_vec() !== e) begin
                n_errors++;
                $display("FAIL mid_reset k=%0d got=%h expected=%h", k, dut_vec(), e);
            end
        end
        rst = 1'b1; emg = 1'b0;
    endtask

    task automatic test_random();
        int emg_left;
        emg_left = 0;
        lanes = 64'h0; dn = 1'b1; ped = 1'b0; emg = 1'b0; emg_lane = 8'h00;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                for (int i = 0; i < 8; i++) begin
                    lanes[8*i +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
                end
            end
            if ($urandom_range(0, 99) == 0) dn = ~dn;
            ped = ($urandom_range(0, 49) == 0);
            if (emg_left == 0 && $urandom_range(0, 199) == 0) begin
                emg_left = $urandom_range(1, 30);
                emg_lane = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            emg = (emg_left > 0);
            if (emg_left > 0) emg_left--;
            rst = ($urandom_range(0, 799) != 0);
            cycle();
            n_checks++;
            if (dut_vec() !== m_vec()) begin
                n_errors++;
                $display("FAIL random k=%0d got=%h expected=%h", k, dut_vec(), m_vec());
            end
        end
        rst = 1'b1; ped = 1'b0; emg = 1'b0;
    endtask

    initial begin
        rst = 1'b0; lanes = 64'h0; dn = 1'b1; ped = 1'b0; emg = 1'b0; emg_lane = 8'h00;
        test_reset();
        test_first_selection();
        test_night_rotation();
        test_ped();
        test_emg_other();
        test_emg_during_ped();
        test_emg_same();
        test_invalid_emg();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
